// File: rtl/adc_sample_buffer.sv
// -----------------------------------------------------------------------------
// adc_sample_buffer
//
// Captures every decimated ADC sample flagged by in_valid into a small circular
// FIFO and hands samples to a consumer over a valid/ready handshake. The ADC
// cannot be stalled, so samples arriving while the FIFO is full (and not being
// popped in the same cycle) are dropped and counted. Each accepted sample is
// tagged with a frame-boundary bit (out_last) every FRAME_LEN accepted samples.
//
// Ports:
//   clk             system clock (single clock domain)
//   rst             synchronous active-high reset
//   in_data         sample from the ADC
//   in_valid        one-cycle ADC strobe, no backpressure possible
//   out_data        head-of-FIFO sample, 0 while out_valid is low
//   out_valid       head sample is available
//   out_ready       consumer accepts the head sample when out_valid is high
//   out_last        head sample closes a frame, 0 while out_valid is low
//   level           current occupancy, 0..DEPTH
//   overflow        sticky: at least one sample was dropped
//   drop_cnt        saturating count of dropped samples
//   clear_overflow  clears overflow and drop_cnt (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module adc_sample_buffer #(
    parameter int ADC_BITLEN  = 16,
    parameter int DEPTH       = 16,
    parameter int FRAME_LEN   = 256,
    parameter int DROP_BITLEN = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADC_BITLEN-1:0]      in_data,
    input  logic                       in_valid,
    output logic [ADC_BITLEN-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [DROP_BITLEN-1:0]     drop_cnt,
    input  logic                       clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Frame counter needs at least one bit even when FRAME_LEN is 1.
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_LEN - 1);
    localparam logic [DROP_BITLEN-1:0] DROP_SAT = '1;

    // Entry layout: {last, data}
    logic [ADC_BITLEN:0] mem [DEPTH];

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic                   overflow_q, overflow_d;
    logic [DROP_BITLEN-1:0] drop_cnt_q, drop_cnt_d;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   push_last;
    logic [ADC_BITLEN:0]    head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign pop  = !empty && out_ready;
    // A full FIFO that is being popped in the same cycle still has room.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign push_last = (frame_q == FRAME_MAX);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        frame_d    = frame_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            frame_d  = push_last ? '0 : frame_q + FW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A drop in the same cycle as a clear restarts the count at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_cnt_d = DROP_BITLEN'(1);
            end else if (drop_cnt_q != DROP_SAT) begin
                drop_cnt_d = drop_cnt_q + DROP_BITLEN'(1);
            end
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            frame_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            frame_q    <= frame_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    // When full and popping, the write lands on the slot being vacated.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= {push_last, in_data};
        end
    end

    // Asynchronous read of the head gives first-word fall-through: a sample
    // pushed at cycle N is visible at N+1. The array is small enough to map
    // to distributed RAM.
    assign head = mem[rd_ptr_q[AW-1:0]];

    assign out_valid = !empty;
    assign out_data  = out_valid ? head[ADC_BITLEN-1:0] : '0;
    assign out_last  = out_valid ? head[ADC_BITLEN]     : 1'b0;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_buffer
//
// Directed testbench for adc_sample_buffer (DEPTH=16, FRAME_LEN=4).
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// acts on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_adc_sample_buffer;

    localparam int ADC_BITLEN  = 16;
    localparam int DEPTH       = 16;
    localparam int FRAME_LEN   = 4;
    localparam int DROP_BITLEN = 16;

    logic                    clk;
    logic                    rst;
    logic [ADC_BITLEN-1:0]   in_data;
    logic                    in_valid;
    logic [ADC_BITLEN-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;
    logic [DROP_BITLEN-1:0]  drop_cnt;
    logic                    clear_overflow;

    int n_total;
    int n_pass;

    adc_sample_buffer #(
        .ADC_BITLEN  (ADC_BITLEN),
        .DEPTH       (DEPTH),
        .FRAME_LEN   (FRAME_LEN),
        .DROP_BITLEN (DROP_BITLEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .level          (level),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    // One clock: rising edge acts, return at the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Hand-computed expectations for the frame test (FRAME_LEN=4).
    // Presented samples 0x301..0x30A; #5 and #6 are dropped while full.
    logic [15:0] frame_data [8] = '{16'h0301, 16'h0302, 16'h0303, 16'h0304,
                                    16'h0307, 16'h0308, 16'h0309, 16'h030A};
    logic        frame_last [8] = '{1'b0, 1'b0, 1'b0, 1'b1,
                                    1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_total        = 0;
        n_pass         = 0;
        rst            = 1'b1;
        in_data        = '0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        step();
        step();
        rst = 1'b0;

        // ---------------- reset values ----------------
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data",  out_data,  0);
        check_eq("rst_out_last",  out_last,  0);
        check_eq("rst_level",     level,     0);
        check_eq("rst_overflow",  overflow,  0);
        check_eq("rst_drop_cnt",  drop_cnt,  0);

        // ---------------- basic push, hold, drain ----------------
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            step();
        end
        in_valid = 1'b0;
        check_eq("t1_level",     level,     3);
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_head",      out_data,  16'h0001);
        step();
        check_eq("t1_hold",      out_data,  16'h0001);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check_eq("t1_drain_data", out_data, 32'(i));
            check_eq("t1_drain_last", out_last, 0);
            step();
        end
        out_ready = 1'b0;
        check_eq("t1_empty_level", level,     0);
        check_eq("t1_empty_valid", out_valid, 0);
        check_eq("t1_empty_data",  out_data,  0);

        // ---------------- overflow: 20 pushes into DEPTH 16 ----------------
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        check_eq("t2_level",    level,    16);
        check_eq("t2_overflow", overflow, 1);
        check_eq("t2_drop_cnt", drop_cnt, 4);

        // ---------------- full + simultaneous push and pop ----------------
        check_eq("t3_head", out_data, 16'h0100);
        in_valid  = 1'b1;
        in_data   = 16'hABCD;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("t3_level",    level,    16);
        check_eq("t3_drop_cnt", drop_cnt, 4);
        for (int i = 1; i < 16; i++) begin
            check_eq("t2_drain", out_data, 32'h0100 + 32'(i));
            step();
        end
        check_eq("t3_new_sample", out_data, 16'hABCD);
        step();
        out_ready = 1'b0;
        check_eq("t2_drained_valid", out_valid, 0);
        check_eq("t2_drained_level", level,     0);

        // ---------------- frame tagging with drops ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0200 + 16'(i);
            step();
        end
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0300 + 16'(k);
            step();
        end
        in_valid = 1'b0;
        check_eq("t4_level",    level,    16);
        check_eq("t4_drop_cnt", drop_cnt, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_eq("t4_filler_data", out_data, 32'h0200 + 32'(i));
            check_eq("t4_filler_last", out_last, ((i % 4) == 3) ? 1 : 0);
            step();
        end
        out_ready = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0300 + 16'(k);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("t4_frame_data", out_data, frame_data[i]);
            check_eq("t4_frame_last", out_last, frame_last[i]);
            step();
        end
        out_ready = 1'b0;
        check_eq("t4_empty", out_valid, 0);

        // ---------------- steady stream with ready held high ----------------
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0400 + 16'(k);
            step();
            in_valid = 1'b0;
            check_eq("t5_latency_data", out_data, 32'h0400 + 32'(k));
            check_eq("t5_level_one",    level,    1);
            step();
            check_eq("t5_level_zero",   level,    0);
            step();
            step();
        end
        out_ready = 1'b0;

        // ---------------- drop counter saturation and clear ----------------
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check_eq("t6_pre_clear_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0500 + 16'(i);
            step();
        end
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        in_valid = 1'b0;
        check_eq("t6_drop_fffe", drop_cnt, 16'hFFFE);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        in_valid = 1'b0;
        check_eq("t6_drop_sat", drop_cnt, 16'hFFFF);
        check_eq("t6_ovf_set",  overflow, 1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check_eq("t6_clear_ovf", overflow, 0);
        check_eq("t6_clear_cnt", drop_cnt, 0);
        clear_overflow = 1'b1;
        in_valid       = 1'b1;
        in_data        = 16'h0FFF;
        step();
        clear_overflow = 1'b0;
        in_valid       = 1'b0;
        check_eq("t6_clr_drop_ovf", overflow, 1);
        check_eq("t6_clr_drop_cnt", drop_cnt, 1);
        check_eq("t6_level_full",   level,    16);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
        end
        out_ready = 1'b0;
        check_eq("t7_level_5", level, 5);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("t7_level",     level,     0);
        check_eq("t7_out_valid", out_valid, 0);
        check_eq("t7_overflow",  overflow,  0);
        check_eq("t7_drop_cnt",  drop_cnt,  0);
        check_eq("t7_out_data",  out_data,  0);
        step();
        check_eq("t7_not_stored", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_sample_buffer.md
# adc_sample_buffer

Downstream stage of the sigma-delta ADC. It captures every decimated sample flagged by the ADC valid pulse into a small circular FIFO and presents the samples to a consumer over a valid/ready handshake. The ADC cannot be stalled, so the block also marks frame boundaries and accounts for samples it had to drop. It decouples the fixed ADC output rate from a bursty consumer such as a UART streamer, DMA or logic analyser.

## Interface
- ADC_BITLEN, 16, sample width; matches the ADC output width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FRAME_LEN, 256, accepted samples per frame; at least 1.
- DROP_BITLEN, 16, width of the drop counter.

- clk  in  1  system clock; the single clock for the block.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  ADC_BITLEN  sample from the ADC output.
- in_valid  in  1  one-cycle strobe from the ADC valid; no backpressure is possible.
- out_data  out  ADC_BITLEN  head-of-FIFO sample.
- out_valid  out  1  head sample is available.
- out_ready  in  1  consumer accepts the head sample when out_valid is also high.
- out_last  out  1  head sample is the last sample of a frame.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one sample was dropped.
- drop_cnt  out  DROP_BITLEN  dropped-sample count; saturates at all-ones.
- clear_overflow  in  1  clears overflow and drop_cnt.

## Operation
- Storage: DEPTH x (ADC_BITLEN+1) entries, holding data plus a last tag. rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide.
  - Full when the pointer MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH.
- Push condition: in_valid && (!full || pop).
  - A full FIFO with a simultaneous pop accepts the new sample. Level stays at DEPTH.
- Pop condition: out_valid && out_ready.
- Drop condition: in_valid && full && !pop.
  - On a drop, the sample is discarded and the FIFO contents are unchanged.
- Frame counter: counts accepted (pushed) samples only, 0..FRAME_LEN-1, then wraps.
  - A pushed sample is tagged last=1 when the counter equals FRAME_LEN-1.
  - With FRAME_LEN=1, every sample is tagged last.
- out_data and out_last read the head entry (first-word fall-through). Both are forced to 0 whenever out_valid=0.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- out_valid = !empty, registered through the pointer update.
- level = wr_ptr - rd_ptr (modulo arithmetic), registered.
- Each drop sets overflow and increments drop_cnt. drop_cnt does not wrap past all-ones.
- clear_overflow:
  - Clears overflow and drop_cnt in the next cycle.
  - If a drop happens in the same cycle, set wins: overflow becomes 1 and drop_cnt becomes 1.
- Reset values of every output: out_valid=0, out_data=0, out_last=0, level=0, overflow=0, drop_cnt=0.
- Reset also clears the pointers and the frame counter. Memory contents are not reset.
- Reset applied mid-operation discards all buffered samples. A sample presented in the reset cycle is not stored.

## Timing
- Push at cycle N (FIFO empty): out_valid=1 and out_data=sample at cycle N+1. Latency is 1 cycle.
- Pop at cycle N: the next head, or out_valid=0, appears at N+1.
- Simultaneous push and pop: level is unchanged at N+1.
- level, overflow and drop_cnt all reflect cycle-N events at N+1.
- A consumer holding out_ready=1 keeps the FIFO drained: with the ADC pulsing every OVERSAMPLE_RATE cycles, level never exceeds 1.
- clear_overflow and rst are sampled on the clk edge only.

## Test plan
- Reset, then 3 samples 0x0001, 0x0002, 0x0003 with out_ready=0 -> level=3 and out_valid=1 with out_data=0x0001 held. Then set out_ready=1 -> 0x0001, 0x0002, 0x0003 on consecutive cycles, level back to 0, out_valid=0, out_data=0.
- DEPTH=16, out_ready=0, push 20 samples -> level=16, overflow=1, drop_cnt=4. Drain -> exactly the first 16 samples come out, in order.
- Full FIFO, in_valid and out_ready both high in the same cycle -> new sample accepted, level stays 16, drop_cnt unchanged.
- FRAME_LEN=4, push 10 samples with 2 dropped in the middle (FIFO full) -> out_last=1 on accepted samples #4 and #8 only.
- drop_cnt at 0xFFFE, 3 more drops -> drop_cnt=0xFFFF. clear_overflow with no drop -> overflow=0, drop_cnt=0. clear_overflow in the same cycle as a drop -> overflow=1, drop_cnt=1.
- Assert rst with level=5 and in_valid=1 in the same cycle -> next cycle level=0, out_valid=0, overflow=0, and the sample is not stored.
